// File: rtl/two_phase_monitor_pkg.sv
// two_phase_pkg: shared types and constants for the two-phase clock monitor.
//   phase_e      - monitor state, 3-bit encoding driven onto the phase output
//   ERR_*        - bit positions of the error flags in the internal error vector
//   *_DEF        - default legal-width limits, in clk cycles
package two_phase_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        C1_HI = 3'd1,
        GAP12 = 3'd2,
        C2_HI = 3'd3,
        GAP21 = 3'd4
    } phase_e;

    localparam int ERR_OVL = 0;
    localparam int ERR_ORD = 1;
    localparam int ERR_WID = 2;
    localparam int ERR_STL = 3;
    localparam int ERR_N   = 4;

    localparam int HI_MIN_DEF  = 6;
    localparam int HI_MAX_DEF  = 10;
    localparam int GAP_MIN_DEF = 2;

endpackage

// File: rtl/two_phase_monitor_sync.sv
// phase_sync: brings one asynchronous phase clock into the clk domain and
// reports its edges.
//   clk, rst_n - system clock, async active-low reset
//   d_i        - asynchronous phase input
//   s_o        - synchronized level (second flop)
//   rise_o     - one-cycle pulse when s_o goes 0->1
//   fall_o     - one-cycle pulse when s_o goes 1->0
module phase_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic s_o,
    output logic rise_o,
    output logic fall_o
);

    // [0] metastability flop, [1] synchronized value, [2] one-cycle delay
    logic [2:0] sh_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sh_q <= '0;
        else        sh_q <= {sh_q[1:0], d_i};
    end

    assign s_o    = sh_q[1];
    assign rise_o =  sh_q[1] & ~sh_q[2];
    assign fall_o = ~sh_q[1] &  sh_q[2];

endmodule

// File: rtl/two_phase_monitor.sv
// two_phase_monitor: checks a non-overlapping two-phase clock pair c1/c2.
// Tracks c1-high, gap, c2-high, gap; measures each high time and gap in clk
// cycles; raises sticky overlap/order/width/stall flags; asserts locked after
// LOCK_CYCLES consecutive clean c1-rise-to-c1-rise cycles.
//   clk, rst_n        - system clock, async active-low reset
//   active            - enable; low forces IDLE, drops locked, blocks new errors
//   c1, c2            - asynchronous phase clocks
//   err_clr           - pulse clearing the sticky error flags
//   phase             - current state (IDLE..GAP21)
//   locked            - LOCK_CYCLES clean cycles seen
//   cycle_count       - completed cycles, wraps
//   last_c1/c2_width  - most recent completed high widths
//   err_overlap/order/width/stall - sticky error flags
module two_phase_monitor
    import two_phase_pkg::*;
#(
    parameter int HI_MIN      = HI_MIN_DEF,
    parameter int HI_MAX      = HI_MAX_DEF,
    parameter int GAP_MIN     = GAP_MIN_DEF,
    parameter int LOCK_CYCLES = 4,
    parameter int WCW         = 8,
    parameter int CCW         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           active,
    input  logic           c1,
    input  logic           c2,
    input  logic           err_clr,
    output logic [2:0]     phase,
    output logic           locked,
    output logic [CCW-1:0] cycle_count,
    output logic [WCW-1:0] last_c1_width,
    output logic [WCW-1:0] last_c2_width,
    output logic           err_overlap,
    output logic           err_order,
    output logic           err_width,
    output logic           err_stall
);

    localparam int LCW = $clog2(LOCK_CYCLES + 1);

    localparam logic [WCW-1:0] WC_SAT    = '1;
    localparam logic [WCW-1:0] HI_MIN_W  = WCW'(HI_MIN);
    localparam logic [WCW-1:0] HI_MAX_W  = WCW'(HI_MAX);
    localparam logic [WCW-1:0] GAP_MIN_W = WCW'(GAP_MIN);
    localparam logic [LCW-1:0] LOCK_W    = LCW'(LOCK_CYCLES);

    logic s1, r1, f1, s2, r2, f2;

    phase_sync u_sync_c1 (.clk(clk), .rst_n(rst_n), .d_i(c1), .s_o(s1), .rise_o(r1), .fall_o(f1));
    phase_sync u_sync_c2 (.clk(clk), .rst_n(rst_n), .d_i(c2), .s_o(s2), .rise_o(r2), .fall_o(f2));

    phase_e           state_q, state_d;
    logic [WCW-1:0]   wc_q, wc_d;
    logic [WCW-1:0]   w1_q, w1_d, w2_q, w2_d;
    logic [CCW-1:0]   cyc_q, cyc_d;
    logic [LCW-1:0]   cln_q, cln_d;
    logic             locked_q, locked_d;
    logic             dirty_q, dirty_d;   // an error was seen since the last c1 rise
    logic [ERR_N-1:0] err_q, err_d, ev;
    logic             cyc_done, err_any;

    always_comb begin
        state_d  = state_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        ev       = '0;
        cyc_done = 1'b0;

        if (!active) begin
            state_d = IDLE;
        end else if (s1 && s2) begin
            ev[ERR_OVL] = 1'b1;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (r1)      state_d = C1_HI;
                    else if (r2) ev[ERR_ORD] = 1'b1;
                end
                C1_HI: begin
                    if (f1) begin
                        w1_d = wc_q;
                        if (wc_q < HI_MIN_W || wc_q > HI_MAX_W) ev[ERR_WID] = 1'b1;
                        // c2 rising in the same cycle is a zero-length gap
                        if (r2) begin
                            ev[ERR_WID] = 1'b1;
                            state_d     = C2_HI;
                        end else begin
                            state_d = GAP12;
                        end
                    end
                end
                GAP12: begin
                    if (r2) begin
                        if (wc_q < GAP_MIN_W) ev[ERR_WID] = 1'b1;
                        state_d = C2_HI;
                    end else if (r1) begin
                        ev[ERR_ORD] = 1'b1;
                        state_d     = IDLE;
                    end
                end
                C2_HI: begin
                    if (f2) begin
                        w2_d = wc_q;
                        if (wc_q < HI_MIN_W || wc_q > HI_MAX_W) ev[ERR_WID] = 1'b1;
                        state_d = GAP21;
                    end
                    if (r1) begin
                        ev[ERR_ORD] = 1'b1;
                        state_d     = IDLE;
                    end
                end
                GAP21: begin
                    if (r1) begin
                        if (wc_q < GAP_MIN_W) ev[ERR_WID] = 1'b1;
                        state_d  = C1_HI;
                        cyc_done = 1'b1;
                    end else if (r2) begin
                        ev[ERR_ORD] = 1'b1;
                        state_d     = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            // Sitting in one state until the counter pins means the source stopped
            if (state_q != IDLE && state_d == state_q && wc_q == WC_SAT) begin
                ev[ERR_STL] = 1'b1;
                state_d     = IDLE;
            end
        end

        err_any = |ev;

        // Counter restarts at 1 on any state entry so it equals the width at exit
        wc_d = wc_q;
        if (active) begin
            if (state_d != state_q) wc_d = WCW'(1);
            else if (wc_q != WC_SAT) wc_d = wc_q + WCW'(1);
        end

        cyc_d = cyc_q;
        if (cyc_done) cyc_d = cyc_q + CCW'(1);

        dirty_d = dirty_q | err_any;
        if (state_d == C1_HI && state_q != C1_HI) dirty_d = 1'b0;

        cln_d = cln_q;
        if (cyc_done && !dirty_q && !err_any && cln_q != LOCK_W) cln_d = cln_q + LCW'(1);
        if (err_any || !active) cln_d = '0;
        locked_d = (cln_d == LOCK_W);

        // A new error outranks a clear in the same cycle
        err_d = (err_q & ~{ERR_N{err_clr}}) | ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wc_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            cyc_q    <= '0;
            cln_q    <= '0;
            locked_q <= 1'b0;
            dirty_q  <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            wc_q     <= wc_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            cyc_q    <= cyc_d;
            cln_q    <= cln_d;
            locked_q <= locked_d;
            dirty_q  <= dirty_d;
            err_q    <= err_d;
        end
    end

    assign phase         = state_q;
    assign locked        = locked_q;
    assign cycle_count   = cyc_q;
    assign last_c1_width = w1_q;
    assign last_c2_width = w2_q;
    assign err_overlap   = err_q[ERR_OVL];
    assign err_order     = err_q[ERR_ORD];
    assign err_width     = err_q[ERR_WID];
    assign err_stall     = err_q[ERR_STL];

endmodule

// File: tb/tb_two_phase_monitor.sv
// Bench for two_phase_monitor: scenario tasks push expected output values into
// a scoreboard queue as they drive c1/c2, then the queue is drained against
// the DUT once the 2-cycle synchronizer latency has passed.
module tb_two_phase_monitor;

    logic        clk = 1'b0;
    logic        rst_n, active, c1, c2, err_clr;
    logic [2:0]  phase;
    logic        locked;
    logic [15:0] cycle_count;
    logic [7:0]  w1, w2;
    logic        eo, er, ew, es;

    always #5 clk = ~clk;

    two_phase_monitor dut (
        .clk(clk), .rst_n(rst_n), .active(active), .c1(c1), .c2(c2), .err_clr(err_clr),
        .phase(phase), .locked(locked), .cycle_count(cycle_count),
        .last_c1_width(w1), .last_c2_width(w2),
        .err_overlap(eo), .err_order(er), .err_width(ew), .err_stall(es)
    );

    // observable selectors
    localparam int S_PH = 0, S_LK = 1, S_CY = 2, S_W1 = 3, S_W2 = 4, S_ER = 5;
    // error vector bits: {stall, width, order, overlap}
    localparam int E_OVL = 1, E_ORD = 2, E_WID = 4, E_STL = 8;

    typedef struct {
        string tag;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            S_PH:    return {29'd0, phase};
            S_LK:    return {31'd0, locked};
            S_CY:    return {16'd0, cycle_count};
            S_W1:    return {24'd0, w1};
            S_W2:    return {24'd0, w2};
            default: return {28'd0, es, ew, er, eo};
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // One full phase period; widths are known from the stimulus itself.
    task automatic period(input int h1, input int g1, input int h2, input int g2);
        c1 = 1'b1; repeat (h1) tick();
        c1 = 1'b0; repeat (g1) tick();
        c2 = 1'b1; repeat (h2) tick();
        c2 = 1'b0; repeat (g2) tick();
        want("per_w1", S_W1, h1);
        want("per_w2", S_W2, h2);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; active = 1'b1; c1 = 1'b0; c2 = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        want("rst_phase", S_PH, 0); want("rst_locked", S_LK, 0); want("rst_cyc", S_CY, 0);
        want("rst_w1", S_W1, 0);    want("rst_w2", S_W2, 0);     want("rst_err", S_ER, 0);
        drain();
        rst_n = 1'b1;
        repeat (2) tick();

        // nominal stream
        repeat (4) period(8, 2, 8, 3);
        want("nom4_locked", S_LK, 0); want("nom4_cyc", S_CY, 3); drain();
        period(8, 2, 8, 3);
        want("nom5_locked", S_LK, 1); want("nom5_cyc", S_CY, 4); drain();
        period(8, 2, 8, 3);
        want("nom6_locked", S_LK, 1); want("nom6_cyc", S_CY, 5); want("nom6_err", S_ER, 0);
        want("nom6_phase", S_PH, 4);
        drain();

        // overlap: c2 rises 3 cycles into c1
        c1 = 1'b1; repeat (3) tick();
        c2 = 1'b1; repeat (2) tick();
        want("ovl_pre_err", S_ER, 0); want("ovl_pre_locked", S_LK, 1); want("ovl_pre_cyc", S_CY, 6);
        drain();
        tick();
        want("ovl_err", S_ER, E_OVL); want("ovl_phase", S_PH, 0); want("ovl_locked", S_LK, 0);
        drain();
        c1 = 1'b0; c2 = 1'b0; repeat (4) tick();
        clear();
        want("ovl_clr", S_ER, 0); drain();
        repeat (5) period(8, 2, 8, 3);
        want("ovl_relock", S_LK, 1); want("ovl_relock_cyc", S_CY, 10); want("ovl_relock_err", S_ER, 0);
        drain();

        // short c1 pulse
        period(4, 2, 8, 3);
        want("short_err", S_ER, E_WID); want("short_locked", S_LK, 0); want("short_cyc", S_CY, 11);
        drain();
        repeat (4) period(8, 2, 8, 3);
        want("short_nolock", S_LK, 0); want("short_cyc4", S_CY, 15); drain();
        period(8, 2, 8, 3);
        want("short_relock", S_LK, 1); want("short_cyc5", S_CY, 16); drain();
        clear();
        want("short_clr", S_ER, 0); drain();

        // c2 pulse while in GAP21
        c2 = 1'b1; repeat (8) tick();
        c2 = 1'b0; repeat (4) tick();
        want("ord_err", S_ER, E_ORD); want("ord_phase", S_PH, 0); want("ord_locked", S_LK, 0);
        want("ord_cyc", S_CY, 16);
        drain();
        clear();

        // c1 stuck high: stall fires when the counter pins at 255
        c1 = 1'b1; repeat (257) tick();
        want("stall_pre_err", S_ER, 0); want("stall_pre_phase", S_PH, 1); drain();
        tick();
        want("stall_err", S_ER, E_STL); want("stall_phase", S_PH, 0); drain();
        repeat (42) tick();
        c1 = 1'b0; repeat (4) tick();
        want("stall_idle", S_PH, 0); want("stall_cyc", S_CY, 16); drain();
        clear();

        // active low: IDLE, locked dropped, counters and widths held
        repeat (5) period(8, 2, 8, 3);
        want("act_pre_locked", S_LK, 1); want("act_pre_cyc", S_CY, 20); drain();
        active = 1'b0; repeat (5) tick();
        c1 = 1'b1; repeat (5) tick();
        c1 = 1'b0; repeat (40) tick();
        want("act_phase", S_PH, 0); want("act_locked", S_LK, 0); want("act_cyc", S_CY, 20);
        want("act_w1", S_W1, 8); want("act_err", S_ER, 0);
        drain();
        active = 1'b1; repeat (2) tick();

        // err_clr in the same cycle as an overlap event
        c1 = 1'b1; repeat (3) tick();
        c2 = 1'b1; repeat (2) tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        want("clr_vs_ovl", S_ER, E_OVL); drain();
        c1 = 1'b0; c2 = 1'b0; repeat (4) tick();

        // async reset in the middle of C2_HI
        c1 = 1'b1; repeat (8) tick();
        c1 = 1'b0; repeat (2) tick();
        c2 = 1'b1; repeat (4) tick();
        want("mid_phase", S_PH, 3); drain();
        #3 rst_n = 1'b0;
        #1;
        want("arst_phase", S_PH, 0); want("arst_locked", S_LK, 0); want("arst_cyc", S_CY, 0);
        want("arst_w1", S_W1, 0);    want("arst_w2", S_W2, 0);     want("arst_err", S_ER, 0);
        drain();
        c2 = 1'b0; repeat (3) tick();
        rst_n = 1'b1; repeat (3) tick();
        want("post_rst_phase", S_PH, 0); want("post_rst_err", S_ER, 0); drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/two_phase_monitor.md
# two_phase_monitor

Synchronous checker for the non-overlapping two-phase clock pair `c1`/`c2` produced by the `clock` generator. It samples both phases on a free-running system clock and tracks the phase sequence c1-high, gap, c2-high, gap. It measures every high time and gap, and flags overlap, ordering, width and stall violations. It reports lock after a run of clean cycles and sits beside the generator as the receiving end of the phase interface.

## Interface
- `HI_MIN`, 6: minimum legal high width of c1 or c2, in clk cycles.
- `HI_MAX`, 10: maximum legal high width of c1 or c2.
- `GAP_MIN`, 2: minimum low time between one phase falling and the other rising.
- `LOCK_CYCLES`, 4: consecutive clean full cycles required before `locked` asserts.
- `WCW`, 8: width-counter bits; the counter saturates at 2^WCW-1.
- `CCW`, 16: cycle-counter bits; the counter wraps.
- `clk` in 1: system clock; all state on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `active` in 1: monitor enable; low forces IDLE and suppresses new errors.
- `c1` in 1: phase-1 clock, asynchronous to clk.
- `c2` in 1: phase-2 clock, asynchronous to clk.
- `err_clr` in 1: single-cycle pulse that clears all sticky error flags.
- `phase` out 3: current state encoding (see Operation).
- `locked` out 1: high after LOCK_CYCLES clean cycles.
- `cycle_count` out CCW: number of completed c1-rise-to-c1-rise cycles.
- `last_c1_width` out WCW: high width of the most recent completed c1 pulse.
- `last_c2_width` out WCW: high width of the most recent completed c2 pulse.
- `err_overlap` out 1: sticky; c1 and c2 were high together.
- `err_order` out 1: sticky; a phase rose out of sequence.
- `err_width` out 1: sticky; a high width was outside [HI_MIN,HI_MAX] or a gap was shorter than GAP_MIN.
- `err_stall` out 1: sticky; the width counter saturated in a non-IDLE state.

## Operation
- Reset values: all outputs 0; `phase`=IDLE; counters 0.
- `c1` and `c2` each pass through a 2-flop synchronizer. Edges are detected on the synchronized value against its one-cycle delay.
- States: IDLE(0), C1_HI(1), GAP12(2), C2_HI(3), GAP21(4).
- Transitions:
  - IDLE→C1_HI on a c1 rise while c2 is low.
  - C1_HI→GAP12 on a c1 fall.
  - GAP12→C2_HI on a c2 rise.
  - C2_HI→GAP21 on a c2 fall.
  - GAP21→C1_HI on a c1 rise. This transition completes one cycle.
- Width counter:
  - Reset to 1 on every state entry; increments each cycle while in a state.
  - On a falling-edge exit, the counter value is latched into `last_cX_width` and checked against HI_MIN/HI_MAX.
  - On a gap exit, the counter is checked against GAP_MIN.
- Overlap (both synchronized phases high, any state): set `err_overlap` and go to IDLE.
- Out-of-order edges set `err_order` and go to IDLE:
  - c2 rise in any state other than GAP12;
  - c1 rise in C1_HI, GAP12 or C2_HI.
- Width violation: set `err_width`. The FSM continues; no resync.
- Stall: counter reaches saturation in a non-IDLE state → set `err_stall` and go to IDLE.
- Clean cycle: a completed cycle with no error set since the previous c1 rise. A clean-cycle counter increments on each clean cycle. `locked`=1 when that counter reaches LOCK_CYCLES, and it saturates there.
- Any error event clears `locked` and the clean-cycle counter in the same cycle.
- `cycle_count` increments on each GAP21→C1_HI transition and wraps at 2^CCW.
- `active` low: state is forced to IDLE and `locked` to 0. Error flags and counters hold their values. On return to high, the monitor waits in IDLE for the next c1 rise.
- `err_clr` in the same cycle as a new error event: the new error wins and its flag stays set.
- Simultaneous c1 fall and c2 rise in one synchronized cycle: C1_HI exits normally, then the measured gap is 0, so `err_width` is set and the FSM enters C2_HI.

## Timing
- An input change first sampled at clk edge N appears on the synchronized signal after edge N+1. `phase`, the error flags and the width outputs update at edge N+2 (latency 2 cycles).
- Measured widths are in clk cycles of the synchronized signal, with ±1 cycle uncertainty relative to the asynchronous input.
- `locked` asserts in the same cycle as the C1_HI entry that completes the LOCK_CYCLES-th clean cycle.
- Asynchronous reset clears all state immediately, including mid-pulse. After reset release the block starts in IDLE.

## Structure
- Package `two_phase_pkg` holds:
  - the state enum (IDLE..GAP21, 3 bits);
  - error-bit index constants;
  - the default values for HI_MIN, HI_MAX and GAP_MIN.
- Sub-module `phase_sync` (2-flop synchronizer plus rise/fall detect), instantiated once per phase.
- Top level holds the FSM, width counter, clean-cycle counter, cycle counter and sticky flags.

## Test plan
All scenarios use default parameters with `active`=1.
- Nominal stream (c1 high 8, gap 2, c2 high 8, gap 3; 21-cycle period, six periods):
  - `locked`=1 after the 5th c1 rise;
  - `cycle_count`=5;
  - `last_c1_width`=`last_c2_width`=8;
  - no errors.
- Overlap (c2 rises 3 cycles into a c1 pulse):
  - `err_overlap`=1 two cycles later;
  - `phase`=IDLE, `locked`=0;
  - after `err_clr`, 4 nominal cycles relock.
- Short pulse (one c1 pulse of 4 cycles):
  - `err_width`=1, `last_c1_width`=4;
  - `locked` drops and returns 4 clean cycles later.
- Order and stall:
  - c2 pulse with no preceding c1 while in GAP21 → `err_order`=1, IDLE;
  - c1 held high for 300 cycles → `err_stall`=1 at count 255.
- Reset, active and err_clr collisions:
  - `rst_n` low mid-C2_HI → all outputs 0 immediately;
  - `active` low for 50 cycles → IDLE, counters held;
  - `err_clr` coincident with an overlap event → `err_overlap` remains 1.
